reduction_accumulator: RTL and testbench

- Sequential stage directly downstream of the reduction block.
- Consumes the packed vector of N/M group results, each (M/2+1) bits wide, with group g at bits [g*GW +: GW].
- Walks the groups one per cycle and accumulates them into a single total.
- Exchanges data over valid/ready handshakes on both sides, so it can sit between registered pipeline stages of the Galois-field datapath.

---
 rtl/reduction_accumulator.sv | 113 +++++++++++
 tb/tb_reduction_accumulator.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/reduction_accumulator.sv
// Serial accumulator behind the reduction stage: walks the packed group results one per cycle
// and sums them behind valid/ready handshakes. Define GF2_MODE_EN to accumulate with XOR instead.
module reduction_accumulator #(
   parameter  int N     = 8,
   parameter  int M     = 4,
   localparam int G     = N / M,
   localparam int GW    = M / 2 + 1,
   localparam int IN_W  = G * GW,
   localparam int SUM_W = GW + $clog2(G)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [IN_W-1:0]   in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [SUM_W-1:0]  out,
   output logic              busy
);

   localparam int IDX_W = (G > 1) ? $clog2(G) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(G - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_ACC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t              state_q, state_d;
   logic [IN_W-1:0]     shift_q, shift_d;
   logic [SUM_W-1:0]    acc_q, acc_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [SUM_W-1:0]    out_q, out_d;
   logic                out_valid_q, out_valid_d;

   logic [GW-1:0]       grp;
   logic [SUM_W-1:0]    sum;

   assign grp = shift_q[GW-1:0];

`ifdef GF2_MODE_EN
   assign sum = acc_q ^ SUM_W'(grp);
`else
   assign sum = acc_q + SUM_W'(grp);
`endif

   always_comb begin
      state_d     = state_q;
      shift_d     = shift_q;
      acc_d       = acc_q;
      idx_d       = idx_q;
      out_d       = out_q;
      out_valid_d = out_valid_q;
      case (state_q)
         S_IDLE: begin
            if (in_valid) begin
               shift_d = in;
               acc_d   = '0;
               idx_d   = '0;
               state_d = S_ACC;
            end
         end
         S_ACC: begin
            acc_d   = sum;
            shift_d = shift_q >> GW;
            idx_d   = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
               // Result gets its own register so it survives the clear of acc on the next acceptance.
               idx_d       = '0;
               out_d       = sum;
               out_valid_d = 1'b1;
               state_d     = S_DONE;
            end
         end
         S_DONE: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: begin
            out_valid_d = 1'b0;
            state_d     = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         shift_q     <= '0;
         acc_q       <= '0;
         idx_q       <= '0;
         out_q       <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         shift_q     <= shift_d;
         acc_q       <= acc_d;
         idx_q       <= idx_d;
         out_q       <= out_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign in_ready  = (state_q == S_IDLE);
   assign busy      = (state_q != S_IDLE);
   assign out_valid = out_valid_q;
   assign out       = out_q;

endmodule

// File: tb/tb_reduction_accumulator.sv
// Directed bench for reduction_accumulator (N=8, M=4: three-bit groups, four-bit total).
module tb_reduction_accumulator;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic [5:0] in_v;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] out_v;
   logic       busy;

   int total_cnt  = 0;
   int passed_cnt = 0;

   reduction_accumulator #(.N(8), .M(4)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in        (in_v),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out       (out_v),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) begin
         passed_cnt++;
         $display("check %-16s observed=%0d expected=%0d", tag, obs, exp);
      end else begin
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   // Presents v for one cycle from IDLE, then measures latency to out_valid and checks out.
   task automatic send_vec(input string tag, input logic [5:0] v, input logic [3:0] exp);
      int cyc;
      check({tag, "_rdy"}, in_ready, 1);
      in_v     = v;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check({tag, "_busy"}, busy, 1);
      cyc = 0;
      while (!out_valid && cyc < 10) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, "_lat"}, cyc, 2);
      check({tag, "_out"}, out_v, exp);
   endtask

   initial begin
      logic [3:0] exp_basic, exp_dist, exp_max, exp_small;
`ifdef GF2_MODE_EN
      exp_basic = 4'd7;
      exp_dist  = 4'd6;
      exp_max   = 4'd0;
      exp_small = 4'd3;
`else
      exp_basic = 4'd7;
      exp_dist  = 4'd8;
      exp_max   = 4'd14;
      exp_small = 4'd3;
`endif
      rst       = 1'b1;
      in_valid  = 1'b0;
      in_v      = '0;
      out_ready = 1'b0;

      // Reset then idle
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_out", out_v, 0);
      check("rst_busy", busy, 0);

      // Basic sum 4+3, result taken one cycle after it appears
      send_vec("basic", 6'b011_100, exp_basic);
      check("basic_ov_hold", out_valid, 1);
      out_ready = 1'b1;
      @(negedge clk);
      check("basic_ov_clr", out_valid, 0);
      check("basic_out_keep", out_v, exp_basic);
      check("basic_idle_rdy", in_ready, 1);
      check("basic_idle_busy", busy, 0);

      // Groups 5 and 3 separate integer from XOR accumulation; out_ready already high
      send_vec("dist", 6'b011_101, exp_dist);
      @(negedge clk);
      check("dist_ov_clr", out_valid, 0);

      send_vec("max", 6'b111_111, exp_max);
      @(negedge clk);
      check("max_ov_clr", out_valid, 0);

      // Backpressure with a competing vector held on the input
      out_ready = 1'b0;
      send_vec("bp", 6'b011_100, exp_basic);
      in_v     = 6'b001_010;
      in_valid = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("bp_out", out_v, exp_basic);
         check("bp_ov", out_valid, 1);
         check("bp_in_ready", in_ready, 0);
      end
      out_ready = 1'b1;
      @(negedge clk);
      check("bp_ov_clr", out_valid, 0);
      check("bp_idle_rdy", in_ready, 1);
      check("bp_out_keep", out_v, exp_basic);
      @(negedge clk);
      in_valid = 1'b0;
      check("bp_accept", busy, 1);
      @(negedge clk);
      @(negedge clk);
      check("bp2_ov", out_valid, 1);
      check("bp2_out", out_v, exp_small);
      @(negedge clk);
      check("bp2_ov_clr", out_valid, 0);

      // Reset during ACC aborts the vector
      in_v     = 6'b111_111;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      check("mid_busy", busy, 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mid_ov", out_valid, 0);
      check("mid_out", out_v, 0);
      check("mid_rdy", in_ready, 1);
      check("mid_busy_clr", busy, 0);
      @(negedge clk);
      @(negedge clk);
      check("mid_no_out", out_valid, 0);
      send_vec("post", 6'b001_010, exp_small);
      @(negedge clk);
      check("post_ov_clr", out_valid, 0);

      $display("%0d/%0d checks passed", passed_cnt, total_cnt);
      $finish;
   end

endmodule
